// File: rtl/cordic_freq_disc.sv
// Frequency discriminator: wrapped phase step between successive CORDIC results, block-averaged.
// Optional squelch enabled by defining CORDIC_FREQ_DISC_SQUELCH_EN.
module cordic_freq_disc #(
    parameter int XY_WDT   = 18,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclr,
    input  logic              en,
    input  logic              vld,
    input  logic [XY_WDT-1:0] mag,
    input  logic [XY_WDT+1:0] ph,
    input  logic [XY_WDT-1:0] thr,
    output logic              rdy,
    output logic [XY_WDT+1:0] freq,
    output logic              sq
);

    localparam int PH_WDT = XY_WDT + 2;
    localparam int D_W    = PH_WDT + 1;
    localparam int ACC_W  = PH_WDT + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic signed [D_W-1:0] PI     = D_W'(longint'(1) << (PH_WDT - 2));
    localparam logic signed [D_W-1:0] TWO_PI = D_W'(longint'(1) << (PH_WDT - 1));
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [PH_WDT-1:0]        r_ph_prev;
    logic [PH_WDT-1:0]        r_freq;
    logic                     r_rdy;
    logic                     r_sq;
    logic                     r_flag;

    state_t                   w_state_next;
    logic [CNT_W-1:0]         w_cnt_next;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic [PH_WDT-1:0]        w_ph_prev_next;
    logic [PH_WDT-1:0]        w_freq_next;
    logic                     w_rdy_next;
    logic                     w_sq_next;
    logic                     w_flag_next;

    logic signed [D_W-1:0]    w_d;
    logic signed [D_W-1:0]    w_d_wrap;
    logic signed [ACC_W-1:0]  w_step;
    logic signed [ACC_W-1:0]  w_sum;
    logic [PH_WDT-1:0]        w_freq_new;
    logic                     w_sq_now;
    logic                     w_last;

`ifdef CORDIC_FREQ_DISC_SQUELCH_EN
    assign w_sq_now = (mag < thr);
`else
    logic w_unused_ok;
    assign w_unused_ok = ^{mag, thr};
    assign w_sq_now    = 1'b0;
`endif

    // One extra bit so the raw difference of two in-range phases never overflows.
    assign w_d = $signed({ph[PH_WDT-1], ph}) - $signed({r_ph_prev[PH_WDT-1], r_ph_prev});

    always_comb begin
        w_d_wrap = w_d;
        if (w_d > PI) begin
            w_d_wrap = w_d - TWO_PI;
        end else if (w_d <= -PI) begin
            w_d_wrap = w_d + TWO_PI;
        end
    end

    assign w_step     = w_sq_now ? '0 : ACC_W'(w_d_wrap);
    assign w_sum      = r_acc + w_step;
    assign w_freq_new = PH_WDT'(w_sum >>> AVG_LOG2);
    assign w_last     = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_acc_next     = r_acc;
        w_ph_prev_next = r_ph_prev;
        w_freq_next    = r_freq;
        w_rdy_next     = 1'b0;
        w_sq_next      = r_sq;
        w_flag_next    = r_flag;
        if (vld) begin
            w_ph_prev_next = ph;
            case (r_state)
                ST_EMPTY: begin
                    w_state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (w_last) begin
                        w_freq_next = w_freq_new;
                        w_rdy_next  = 1'b1;
                        w_sq_next   = r_flag | w_sq_now;
                        w_flag_next = 1'b0;
                        w_acc_next  = '0;
                        w_cnt_next  = '0;
                    end else begin
                        w_acc_next  = w_sum;
                        w_cnt_next  = r_cnt + 1'b1;
                        w_flag_next = r_flag | w_sq_now;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // sclr outranks en so a frozen pipeline can still be flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_EMPTY;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_ph_prev <= '0;
            r_freq    <= '0;
            r_rdy     <= 1'b0;
            r_sq      <= 1'b0;
            r_flag    <= 1'b0;
        end else if (sclr) begin
            r_state   <= ST_EMPTY;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_ph_prev <= '0;
            r_freq    <= '0;
            r_rdy     <= 1'b0;
            r_sq      <= 1'b0;
            r_flag    <= 1'b0;
        end else if (en) begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_acc     <= w_acc_next;
            r_ph_prev <= w_ph_prev_next;
            r_freq    <= w_freq_next;
            r_rdy     <= w_rdy_next;
            r_sq      <= w_sq_next;
            r_flag    <= w_flag_next;
        end
    end

    assign rdy  = r_rdy;
    assign freq = r_freq;
    assign sq   = r_sq;

endmodule

// File: tb/tb_cordic_freq_disc.sv
// Directed bench for cordic_freq_disc: one averaging instance (AVG_LOG2=2) and one pass-through (AVG_LOG2=0).
module tb_cordic_freq_disc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclr = 1'b0;
    logic        en = 1'b1;
    logic        vld = 1'b0;
    logic [17:0] mag = 18'd1000;
    logic [17:0] thr = 18'd100;
    logic [19:0] ph = 20'd0;
    logic        rdy, sq, rdy0, sq0;
    logic [19:0] freq, freq0;

    int checks = 0;
    int failures = 0;
    int q_freq[$];
    int q_sq[$];
    int q0[$];

    always #5 clk = ~clk;

    cordic_freq_disc #(.XY_WDT(18), .AVG_LOG2(2)) dut (
        .clk(clk), .reset(reset), .sclr(sclr), .en(en), .vld(vld),
        .mag(mag), .ph(ph), .thr(thr), .rdy(rdy), .freq(freq), .sq(sq)
    );

    cordic_freq_disc #(.XY_WDT(18), .AVG_LOG2(0)) dut0 (
        .clk(clk), .reset(reset), .sclr(sclr), .en(en), .vld(vld),
        .mag(mag), .ph(ph), .thr(thr), .rdy(rdy0), .freq(freq0), .sq(sq0)
    );

    always @(posedge clk) begin
        #1;
        if (rdy === 1'b1) begin
            q_freq.push_back(int'($signed(freq)));
            q_sq.push_back(int'(sq));
            $display("t=%0t avg4 rdy freq=%0d sq=%0b", $time, $signed(freq), sq);
        end
        if (rdy0 === 1'b1) begin
            q0.push_back(int'($signed(freq0)));
        end
    end

    // All tasks start and end on a falling edge.
    task automatic send_m(input int p, input int m, input int gap);
        ph  = 20'(p);
        mag = 18'(m);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        mag = 18'd1000;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send(input int p, input int gap);
        send_m(p, 1000, gap);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        q_freq.delete();
        q_sq.delete();
        q0.delete();
    endtask

    task automatic test_reset();
        checks++;
        if (rdy !== 1'b0 || freq !== 20'd0 || sq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b freq=%0d sq=%b exp 0/0/0", rdy, freq, sq);
        end
        checks++;
        if (rdy0 !== 1'b0 || freq0 !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs0 got rdy=%b freq=%0d exp 0/0", rdy0, freq0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q_freq.size() != 0 || rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got pulses=%0d rdy=%b exp 0/0", q_freq.size(), rdy);
        end
    endtask

    task automatic test_ramp();
        int got;
        do_reset();
        for (int i = 0; i < 9; i++) send(i * 1000, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (q_freq.size() != 2) begin
            failures++;
            $display("FAIL ramp_count got=%0d exp=2", q_freq.size());
        end
        for (int k = 0; k < 2; k++) begin
            got = (k < q_freq.size()) ? q_freq[k] : -9999999;
            checks++;
            if (got !== 1000) begin
                failures++;
                $display("FAIL ramp_freq[%0d] got=%0d exp=1000", k, got);
            end
            got = (k < q_sq.size()) ? q_sq[k] : -1;
            checks++;
            if (got !== 0) begin
                failures++;
                $display("FAIL ramp_sq[%0d] got=%0d exp=0", k, got);
            end
        end
        checks++;
        if (q0.size() != 8) begin
            failures++;
            $display("FAIL ramp0_count got=%0d exp=8", q0.size());
        end
        for (int k = 0; k < 8; k++) begin
            got = (k < q0.size()) ? q0[k] : -9999999;
            checks++;
            if (got !== 1000) begin
                failures++;
                $display("FAIL ramp0_freq[%0d] got=%0d exp=1000", k, got);
            end
        end
        checks++;
        if (rdy !== 1'b0 || freq !== 20'd1000) begin
            failures++;
            $display("FAIL ramp_hold got rdy=%b freq=%0d exp 0/1000", rdy, freq);
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (freq !== 20'd0 || rdy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got freq=%0d rdy=%b exp 0/0", freq, rdy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int p[6];
        int e[5];
        int got;
        p = '{262134, -262134, 262134, 131072, -131072, 131072};
        e = '{20, -20, -131062, 262144, 262144};
        do_reset();
        for (int i = 0; i < 6; i++) send(p[i], 0);
        repeat (2) @(negedge clk);
        checks++;
        if (q0.size() != 5) begin
            failures++;
            $display("FAIL wrap_count got=%0d exp=5", q0.size());
        end
        for (int k = 0; k < 5; k++) begin
            got = (k < q0.size()) ? q0[k] : -9999999;
            checks++;
            if (got !== e[k]) begin
                failures++;
                $display("FAIL wrap_freq[%0d] got=%0d exp=%0d", k, got, e[k]);
            end
        end
    endtask

    task automatic test_floor();
        int p[9];
        int e0[8];
        int e[2];
        int got;
        p  = '{0, -1, -2, -3, -5, -4, -3, -2, 0};
        e0 = '{-1, -1, -1, -2, 1, 1, 1, 2};
        e  = '{-2, 1};
        do_reset();
        for (int i = 0; i < 9; i++) send(p[i], 0);
        repeat (2) @(negedge clk);
        checks++;
        if (q_freq.size() != 2) begin
            failures++;
            $display("FAIL floor_count got=%0d exp=2", q_freq.size());
        end
        for (int k = 0; k < 2; k++) begin
            got = (k < q_freq.size()) ? q_freq[k] : -9999999;
            checks++;
            if (got !== e[k]) begin
                failures++;
                $display("FAIL floor_freq[%0d] got=%0d exp=%0d", k, got, e[k]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            got = (k < q0.size()) ? q0[k] : -9999999;
            checks++;
            if (got !== e0[k]) begin
                failures++;
                $display("FAIL floor0_freq[%0d] got=%0d exp=%0d", k, got, e0[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int got;
        do_reset();
        for (int i = 0; i < 3; i++) send(i * 500, 0);
        do_reset();
        for (int i = 0; i < 4; i++) send(i * 500, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (q_freq.size() != 0) begin
            failures++;
            $display("FAIL midreset_early got pulses=%0d exp=0", q_freq.size());
        end
        send(2000, 2);
        got = (q_freq.size() > 0) ? q_freq[0] : -9999999;
        checks++;
        if (q_freq.size() != 1 || got !== 500) begin
            failures++;
            $display("FAIL midreset_freq got pulses=%0d freq=%0d exp 1/500", q_freq.size(), got);
        end
    endtask

    task automatic test_sclr();
        int got;
        do_reset();
        for (int i = 0; i < 3; i++) send(i * 500, 0);
        sclr = 1'b1;
        vld  = 1'b1;
        ph   = 20'd99999;
        @(negedge clk);
        sclr = 1'b0;
        vld  = 1'b0;
        for (int i = 0; i < 4; i++) send(3000 + i * 500, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (q_freq.size() != 0) begin
            failures++;
            $display("FAIL sclr_early got pulses=%0d exp=0", q_freq.size());
        end
        send(5000, 2);
        got = (q_freq.size() > 0) ? q_freq[0] : -9999999;
        checks++;
        if (q_freq.size() != 1 || got !== 500) begin
            failures++;
            $display("FAIL sclr_freq got pulses=%0d freq=%0d exp 1/500", q_freq.size(), got);
        end
    endtask

    task automatic test_enable();
        int got;
        do_reset();
        send(0, 0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) send(77777, 1);
        en = 1'b1;
        for (int i = 1; i < 9; i++) send(i * 1000, (i * 7) % 20);
        repeat (2) @(negedge clk);
        checks++;
        if (q_freq.size() != 2) begin
            failures++;
            $display("FAIL enable_count got=%0d exp=2", q_freq.size());
        end
        for (int k = 0; k < 2; k++) begin
            got = (k < q_freq.size()) ? q_freq[k] : -9999999;
            checks++;
            if (got !== 1000) begin
                failures++;
                $display("FAIL enable_freq[%0d] got=%0d exp=1000", k, got);
            end
        end
        en   = 1'b0;
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        en   = 1'b1;
        checks++;
        if (freq !== 20'd0) begin
            failures++;
            $display("FAIL sclr_while_disabled got freq=%0d exp=0", freq);
        end
    endtask

    task automatic test_squelch();
        int ef[2];
        int es[2];
        int got;
`ifdef CORDIC_FREQ_DISC_SQUELCH_EN
        ef = '{300, 400};
        es = '{1, 0};
`else
        ef = '{400, 400};
        es = '{0, 0};
`endif
        do_reset();
        thr = 18'd100;
        send(0, 0);
        send(400, 0);
        send(800, 0);
        send_m(1200, 50, 0);
        send(1600, 0);
        for (int i = 0; i < 4; i++) send(2000 + i * 400, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (q_freq.size() != 2) begin
            failures++;
            $display("FAIL squelch_count got=%0d exp=2", q_freq.size());
        end
        for (int k = 0; k < 2; k++) begin
            got = (k < q_freq.size()) ? q_freq[k] : -9999999;
            checks++;
            if (got !== ef[k]) begin
                failures++;
                $display("FAIL squelch_freq[%0d] got=%0d exp=%0d", k, got, ef[k]);
            end
            got = (k < q_sq.size()) ? q_sq[k] : -1;
            checks++;
            if (got !== es[k]) begin
                failures++;
                $display("FAIL squelch_sq[%0d] got=%0d exp=%0d", k, got, es[k]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ramp();
        test_async_reset();
        test_wrap();
        test_floor();
        test_mid_reset();
        test_sclr();
        test_enable();
        test_squelch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
